// File: rtl/apb_periph_node_if.sv
// Upstream APB bus bundle for the peripheral node.
// The master modport drives the request and the slave modport drives the response.
interface apb_periph_node_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_periph_node.sv
// APB 1-to-N peripheral node with a runtime address map and a per-slave enable mask.
// All outputs are registered: every output register is loaded from the next-state
// decision, so each output lines up with the FSM state that it belongs to.
// Unmapped addresses and slaves that stall past the wait limit produce an error
// response, and a saturating counter records each such error.
module apb_periph_node #(
    parameter int NB_SLAVE       = 9,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
    input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
    input  logic [NB_SLAVE-1:0]                          slave_en_i,
    apb_periph_node_if.slave                             up,
    output logic [APB_ADDR_WIDTH-1:0]                    m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                    m_pwdata_o,
    output logic                                         m_pwrite_o,
    output logic [NB_SLAVE-1:0]                          m_psel_o,
    output logic                                         m_penable_o,
    input  logic [NB_SLAVE-1:0][APB_DATA_WIDTH-1:0]      m_prdata_i,
    input  logic [NB_SLAVE-1:0]                          m_pready_i,
    input  logic [NB_SLAVE-1:0]                          m_pslverr_i,
    output logic                                         err_o,
    output logic                                         timeout_o,
    output logic [APB_ADDR_WIDTH-1:0]                    err_addr_o,
    output logic [ERR_CNT_WIDTH-1:0]                     err_cnt_o,
    input  logic                                         err_clr_i
);

    localparam int IDX_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                       state_r, state_s;
    logic [IDX_W-1:0]             idx_r, idx_s;
    logic [TO_W-1:0]              wait_cnt_r, wait_cnt_s;
    logic [APB_ADDR_WIDTH-1:0]    paddr_r;
    logic [APB_DATA_WIDTH-1:0]    pwdata_r;
    logic                         pwrite_r;
    logic [NB_SLAVE-1:0]          m_psel_r;
    logic                         m_penable_r;
    logic [APB_DATA_WIDTH-1:0]    prdata_r;
    logic                         pready_r;
    logic                         pslverr_r;
    logic                         err_r;
    logic                         timeout_r;
    logic [APB_ADDR_WIDTH-1:0]    err_addr_r;
    logic [ERR_CNT_WIDTH-1:0]     err_cnt_r;

    logic                         hit_s;
    logic [IDX_W-1:0]             hit_idx_s;
    logic                         cap_s;
    logic                         dec_err_s;
    logic                         to_err_s;
    logic                         resp_err_s;
    logic [APB_DATA_WIDTH-1:0]    resp_data_s;
    logic [APB_ADDR_WIDTH-1:0]    err_addr_s;

    // One-hot select vector for a stored slave index.
    function automatic logic [NB_SLAVE-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NB_SLAVE-1:0] v;
        v = {NB_SLAVE{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // The address decoder scans from the highest index down, so when ranges overlap the lowest enabled index wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = NB_SLAVE - 1; i >= 0; i--) begin
            if (slave_en_i[i] && (up.paddr >= start_addr_i[i]) && (up.paddr <= end_addr_i[i])) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // FSM state register, with the stored slave index and the wait counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            idx_r      <= {IDX_W{1'b0}};
            wait_cnt_r <= {TO_W{1'b0}};
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state logic, plus the response and error values to load when RESP is entered.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        wait_cnt_s  = wait_cnt_r;
        cap_s       = 1'b0;
        dec_err_s   = 1'b0;
        to_err_s    = 1'b0;
        resp_err_s  = 1'b0;
        resp_data_s = {APB_DATA_WIDTH{1'b0}};
        err_addr_s  = paddr_r;
        case (state_r)
            IDLE: begin
                if (up.psel && !up.penable) begin
                    cap_s = 1'b1;
                    if (hit_s) begin
                        state_s = SETUP;
                        idx_s   = hit_idx_s;
                    end else begin
                        state_s    = RESP;
                        dec_err_s  = 1'b1;
                        resp_err_s = 1'b1;
                        err_addr_s = up.paddr;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s    = ACCESS;
                wait_cnt_s = {TO_W{1'b0}};
            end
            ACCESS: begin
                // If pready and the wait limit occur in the same cycle, pready is checked first and wins.
                if (m_pready_i[idx_r]) begin
                    state_s     = RESP;
                    resp_data_s = m_prdata_i[idx_r];
                    resp_err_s  = m_pslverr_i[idx_r];
                end else if (TO_EN && (wait_cnt_r == TO_MAX)) begin
                    state_s    = RESP;
                    to_err_s   = 1'b1;
                    resp_err_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + TO_W'(1'b1);
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered upstream response, downstream request and captured sideband.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            paddr_r     <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r    <= {APB_DATA_WIDTH{1'b0}};
            pwrite_r    <= 1'b0;
            m_psel_r    <= {NB_SLAVE{1'b0}};
            m_penable_r <= 1'b0;
            prdata_r    <= {APB_DATA_WIDTH{1'b0}};
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
        end else begin
            if (cap_s) begin
                paddr_r  <= up.paddr;
                pwdata_r <= up.pwdata;
                pwrite_r <= up.pwrite;
            end else begin
                paddr_r  <= paddr_r;
                pwdata_r <= pwdata_r;
                pwrite_r <= pwrite_r;
            end
            if ((state_s == SETUP) || (state_s == ACCESS)) begin
                m_psel_r <= onehot(idx_s);
            end else begin
                m_psel_r <= {NB_SLAVE{1'b0}};
            end
            m_penable_r <= (state_s == ACCESS);
            pready_r    <= (state_s == RESP);
            pslverr_r   <= resp_err_s;
            prdata_r    <= resp_data_s;
        end
    end

    // Error pulses and bookkeeping. A clear overrides an error that arrives in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_r      <= 1'b0;
            timeout_r  <= 1'b0;
            err_addr_r <= {APB_ADDR_WIDTH{1'b0}};
            err_cnt_r  <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            err_r     <= dec_err_s | to_err_s;
            timeout_r <= to_err_s;
            if (err_clr_i) begin
                err_addr_r <= {APB_ADDR_WIDTH{1'b0}};
                err_cnt_r  <= {ERR_CNT_WIDTH{1'b0}};
            end else if (dec_err_s || to_err_s) begin
                err_addr_r <= err_addr_s;
                if (err_cnt_r != {ERR_CNT_WIDTH{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1'b1);
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                err_addr_r <= err_addr_r;
                err_cnt_r  <= err_cnt_r;
            end
        end
    end

    assign up.prdata   = prdata_r;
    assign up.pready   = pready_r;
    assign up.pslverr  = pslverr_r;
    assign m_paddr_o   = paddr_r;
    assign m_pwdata_o  = pwdata_r;
    assign m_pwrite_o  = pwrite_r;
    assign m_psel_o    = m_psel_r;
    assign m_penable_o = m_penable_r;
    assign err_o       = err_r;
    assign timeout_o   = timeout_r;
    assign err_addr_o  = err_addr_r;
    assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_apb_periph_node.sv
// Directed bench for apb_periph_node: nine behavioural slaves with per-slave wait counts.
module tb_apb_periph_node;

    localparam int NS = 9;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [NS-1:0][31:0] start_addr, end_addr;
    logic [NS-1:0]       slave_en;
    logic [31:0]         m_paddr, m_pwdata;
    logic                m_pwrite;
    logic [NS-1:0]       m_psel;
    logic                m_penable;
    logic [NS-1:0][31:0] m_prdata;
    logic [NS-1:0]       m_pready, m_pslverr;
    logic                err, timeout;
    logic [31:0]         err_addr;
    logic [7:0]          err_cnt;
    logic                err_clr = 1'b0;

    int          wait_cfg  [NS];
    logic [31:0] rdata_cfg [NS];
    logic [NS-1:0] serr_cfg;
    int          acc_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    apb_periph_node_if #(.ADDR_W(32), .DATA_W(32)) up_if ();

    apb_periph_node #(
        .NB_SLAVE(NS), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4), .ERR_CNT_WIDTH(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .start_addr_i(start_addr), .end_addr_i(end_addr), .slave_en_i(slave_en),
        .up(up_if.slave),
        .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata), .m_pwrite_o(m_pwrite),
        .m_psel_o(m_psel), .m_penable_o(m_penable),
        .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
        .err_o(err), .timeout_o(timeout), .err_addr_o(err_addr), .err_cnt_o(err_cnt),
        .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    // Number of ACCESS cycles already spent on the current downstream transfer.
    always @(posedge clk) begin
        if (m_penable) acc_cnt <= acc_cnt + 1;
        else           acc_cnt <= 0;
    end

    // Slave i answers in the ACCESS cycle whose index equals wait_cfg[i].
    always_comb begin
        m_pready  = '0;
        m_prdata  = '0;
        m_pslverr = '0;
        for (int i = 0; i < NS; i++) begin
            m_pready[i]  = m_psel[i] & m_penable & (acc_cnt == wait_cfg[i]);
            m_prdata[i]  = rdata_cfg[i];
            m_pslverr[i] = serr_cfg[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a setup phase and clock it in; on return the bench is in cycle T0+1.
    task automatic start(input logic [31:0] a, input logic [31:0] d, input logic w);
        up_if.paddr   = a;
        up_if.pwdata  = d;
        up_if.pwrite  = w;
        up_if.psel    = 1'b1;
        up_if.penable = 1'b0;
        tick();
        up_if.penable = 1'b1;
    endtask

    task automatic end_xfer();
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
    endtask

    initial begin
        up_if.paddr = '0; up_if.pwdata = '0; up_if.pwrite = 1'b0;
        up_if.psel = 1'b0; up_if.penable = 1'b0;
        serr_cfg = '0;
        for (int i = 0; i < NS; i++) begin
            start_addr[i] = 32'hFFFF_FFFF;
            end_addr[i]   = 32'h0000_0000;
            wait_cfg[i]   = 0;
            rdata_cfg[i]  = 32'h0;
        end
        start_addr[0] = 32'h1A10_0000; end_addr[0] = 32'h1A10_0FFF;
        start_addr[1] = 32'h1A10_1000; end_addr[1] = 32'h1A10_1FFF;
        start_addr[2] = 32'h2000_0000; end_addr[2] = 32'h2000_FFFF;
        start_addr[3] = 32'h4000_0000; end_addr[3] = 32'h4000_00FF;
        start_addr[5] = 32'h2000_0000; end_addr[5] = 32'h2000_FFFF;
        slave_en = 9'h1FF;
        wait_cfg[1] = 3;   rdata_cfg[1] = 32'h1234_5678;
        wait_cfg[3] = 1000;
        rdata_cfg[0] = 32'hA5A5_0001;

        tick(); tick();
        rst_ni = 1'b1;
        check("rst_pready", up_if.pready, 32'h0);
        check("rst_psel", m_psel, 32'h0);
        check("rst_penable", m_penable, 32'h0);
        check("rst_err_cnt", err_cnt, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);

        // Zero-wait write to slave 0
        start(32'h1A10_0004, 32'hCAFE_F00D, 1'b1);
        check("wr_setup_psel", m_psel, 32'h001);
        check("wr_setup_penable", m_penable, 32'h0);
        check("wr_m_paddr", m_paddr, 32'h1A10_0004);
        check("wr_m_pwdata", m_pwdata, 32'hCAFE_F00D);
        check("wr_m_pwrite", m_pwrite, 32'h1);
        tick();
        check("wr_acc_psel", m_psel, 32'h001);
        check("wr_acc_penable", m_penable, 32'h1);
        check("wr_acc_pready", up_if.pready, 32'h0);
        tick();
        check("wr_pready", up_if.pready, 32'h1);
        check("wr_pslverr", up_if.pslverr, 32'h0);
        end_xfer();
        tick();
        check("wr_after_pready", up_if.pready, 32'h0);
        check("wr_after_psel", m_psel, 32'h0);
        check("wr_hold_paddr", m_paddr, 32'h1A10_0004);

        // Read slave 1, 3 wait states: ready coincides with the wait limit and must win
        start(32'h1A10_1008, 32'h0, 1'b0);
        tick(); tick(); tick(); tick();
        check("rd1_t5_pready", up_if.pready, 32'h0);
        check("rd1_t5_psel", m_psel, 32'h002);
        tick();
        check("rd1_pready", up_if.pready, 32'h1);
        check("rd1_prdata", up_if.prdata, 32'h1234_5678);
        check("rd1_pslverr", up_if.pslverr, 32'h0);
        check("rd1_no_timeout", timeout, 32'h0);
        check("rd1_err_cnt", err_cnt, 32'h0);
        end_xfer();
        tick();
        check("rd1_prdata_idle", up_if.prdata, 32'h0);

        // Slave-reported error is passed through but not counted
        wait_cfg[1] = 0; serr_cfg[1] = 1'b1;
        start(32'h1A10_1000, 32'h55, 1'b1);
        tick(); tick();
        check("serr_pslverr", up_if.pslverr, 32'h1);
        check("serr_err_o", err, 32'h0);
        check("serr_err_cnt", err_cnt, 32'h0);
        end_xfer(); serr_cfg[1] = 1'b0;
        tick();

        // Decode misses
        start(32'h0000_0000, 32'h0, 1'b0);
        check("miss0_pready", up_if.pready, 32'h1);
        check("miss0_pslverr", up_if.pslverr, 32'h1);
        check("miss0_prdata", up_if.prdata, 32'h0);
        check("miss0_err_cnt", err_cnt, 32'h1);
        check("miss0_err_addr", err_addr, 32'h0);
        check("miss0_err_o", err, 32'h1);
        check("miss0_timeout", timeout, 32'h0);
        check("miss0_psel", m_psel, 32'h0);
        end_xfer();
        tick();
        check("miss0_err_o_drop", err, 32'h0);
        start(32'h3000_0000, 32'h0, 1'b0);
        check("miss1_err_cnt", err_cnt, 32'h2);
        check("miss1_err_addr", err_addr, 32'h3000_0000);
        end_xfer();
        tick();

        // Timeout on slave 3 (never ready), limit of 4 cycles
        start(32'h4000_0010, 32'h0, 1'b0);
        tick(); tick(); tick(); tick();
        check("to_t5_psel", m_psel, 32'h008);
        check("to_t5_pready", up_if.pready, 32'h0);
        tick();
        check("to_pready", up_if.pready, 32'h1);
        check("to_pslverr", up_if.pslverr, 32'h1);
        check("to_timeout", timeout, 32'h1);
        check("to_err_o", err, 32'h1);
        check("to_psel", m_psel, 32'h0);
        check("to_penable", m_penable, 32'h0);
        check("to_err_cnt", err_cnt, 32'h3);
        check("to_err_addr", err_addr, 32'h4000_0010);
        check("to_prdata", up_if.prdata, 32'h0);
        end_xfer();
        tick();
        check("to_timeout_drop", timeout, 32'h0);

        // Overlapping slaves 2 and 5: lowest enabled index wins
        start(32'h2000_0100, 32'h0, 1'b0);
        check("ovl_sel2", m_psel, 32'h004);
        tick(); tick();
        end_xfer();
        tick();
        slave_en[2] = 1'b0;
        start(32'h2000_0100, 32'h0, 1'b0);
        check("ovl_sel5", m_psel, 32'h020);
        tick(); tick();
        check("ovl5_pready", up_if.pready, 32'h1);
        end_xfer();
        tick();

        // Saturation of the error counter
        for (int k = 0; k < 300; k++) begin
            start(32'h5000_0000, 32'h0, 1'b0);
            end_xfer();
            tick();
        end
        check("sat_err_cnt", err_cnt, 32'hFF);
        check("sat_err_addr", err_addr, 32'h5000_0000);

        // Clear together with a new error
        up_if.paddr = 32'h6000_0000; up_if.psel = 1'b1; up_if.penable = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_pready", up_if.pready, 32'h1);
        check("clr_pslverr", up_if.pslverr, 32'h1);
        check("clr_err_cnt", err_cnt, 32'h0);
        check("clr_err_addr", err_addr, 32'h0);
        end_xfer();
        tick();
        start(32'h6000_0004, 32'h0, 1'b0);
        check("clr_next_cnt", err_cnt, 32'h1);
        end_xfer();
        tick();

        // Reset in the middle of ACCESS
        start(32'h4000_0000, 32'h0, 1'b0);
        tick();
        check("mid_penable", m_penable, 32'h1);
        rst_ni = 1'b0;
        end_xfer();
        tick();
        check("mid_rst_psel", m_psel, 32'h0);
        check("mid_rst_penable", m_penable, 32'h0);
        check("mid_rst_pready", up_if.pready, 32'h0);
        check("mid_rst_err_cnt", err_cnt, 32'h0);
        rst_ni = 1'b1;
        start(32'h1A10_0010, 32'h0, 1'b0);
        check("post_rst_setup", m_psel, 32'h001);
        tick(); tick();
        check("post_rst_pready", up_if.pready, 32'h1);
        check("post_rst_prdata", up_if.prdata, 32'hA5A5_0001);
        end_xfer();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
